video_timing_gen: RTL and testbench

// - Raster timing generator on the 25.178571 MHz pixel clock output of the video PLL (640x480@60 default).
// - Sits directly downstream of the PLL: consumes the pixel clock and the PLL locked flag.
// - Produces hsync/vsync/de/counters for the TMDS encoder stage.
// - Produces a pixel-request strobe PREFETCH cycles ahead of de for framebuffer fetch.

---
 rtl/video_timing_gen.sv | 143 ++++++++++++++
 tb/tb_video_timing_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: master h/v counters, a registered pixel-request strobe, and a
// PREFETCH-deep delay pipe that aligns de/hsync/vsync/hcount/vcount/sof.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PREFETCH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
  output logic        pix_req,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        sof
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] HS_FIRST   = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_LAST    = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] VS_FIRST   = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_LAST    = 12'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic        H_ACTIVE_L = (H_POL != 0);
  localparam logic        V_ACTIVE_L = (V_POL != 0);

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic        sof;
    logic [11:0] h;
    logic [11:0] v;
  } stage_t;

  // locked comes from the PLL's own domain; two flops before it gates anything
  logic lock_meta_reg;
  logic run_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      run_reg       <= 1'b0;
    end else begin
      lock_meta_reg <= locked;
      run_reg       <= lock_meta_reg;
    end
  end

  logic [11:0] mh_reg, mh_next;
  logic [11:0] mv_reg, mv_next;

  always_comb begin
    mh_next = mh_reg;
    mv_next = mv_reg;
    if (!run_reg) begin
      mh_next = '0;
      mv_next = '0;
    end else if (mh_reg == H_LAST) begin
      mh_next = '0;
      mv_next = (mv_reg == V_LAST) ? 12'd0 : mv_reg + 12'd1;
    end else begin
      mh_next = mh_reg + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mh_reg <= '0;
      mv_reg <= '0;
    end else begin
      mh_reg <= mh_next;
      mv_reg <= mv_next;
    end
  end

  stage_t stage_next;

  always_comb begin
    stage_next     = '0;
    stage_next.act = (mh_reg < H_ACT) && (mv_reg < V_ACT);
    stage_next.hs  = (mh_reg >= HS_FIRST) && (mh_reg <= HS_LAST);
    stage_next.vs  = (mv_reg >= VS_FIRST) && (mv_reg <= VS_LAST);
    stage_next.sof = (mh_reg == 12'd0) && (mv_reg == 12'd0);
    stage_next.h   = mh_reg;
    stage_next.v   = mv_reg;
  end

  // Stage 0 feeds pix_req; stage PREFETCH feeds the aligned video outputs.
  stage_t pipe_reg [0:PREFETCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_reg[0] <= '0;
    end else if (!run_reg) begin
      pipe_reg[0] <= '0;
    end else begin
      pipe_reg[0] <= stage_next;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= PREFETCH; gi++) begin : g_pipe
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_reg[gi] <= '0;
        end else if (!run_reg) begin
          pipe_reg[gi] <= '0;
        end else begin
          pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  stage_t out_stage;
  assign out_stage = pipe_reg[PREFETCH];

  assign pix_req = pipe_reg[0].act;
  assign de      = out_stage.act;
  assign hsync   = out_stage.hs ? H_ACTIVE_L : ~H_ACTIVE_L;
  assign vsync   = out_stage.vs ? V_ACTIVE_L : ~V_ACTIVE_L;
  assign hcount  = out_stage.h;
  assign vcount  = out_stage.v;
  assign sof     = out_stage.sof;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: default 640x480 timing plus two shrunken rasters
// exercising PREFETCH=1 and PREFETCH=8 with inverted sync polarity.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic locked;

  always #20 clk = ~clk;

  typedef struct packed {
    logic        pix_req;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        sof;
    logic [11:0] hc;
    logic [11:0] vc;
  } obs_t;

  int checks = 0;
  int errors = 0;

  logic        d_pix_req, d_de, d_hsync, d_vsync, d_sof;
  logic [11:0] d_hcount, d_vcount;
  logic        a_pix_req, a_de, a_hsync, a_vsync, a_sof;
  logic [11:0] a_hcount, a_vcount;
  logic        b_pix_req, b_de, b_hsync, b_vsync, b_sof;
  logic [11:0] b_hcount, b_vcount;

  obs_t obs_def, obs_p1, obs_p8;
  assign obs_def = {d_pix_req, d_de, d_hsync, d_vsync, d_sof, d_hcount, d_vcount};
  assign obs_p1  = {a_pix_req, a_de, a_hsync, a_vsync, a_sof, a_hcount, a_vcount};
  assign obs_p8  = {b_pix_req, b_de, b_hsync, b_vsync, b_sof, b_hcount, b_vcount};

  video_timing_gen u_def (
    .clk(clk), .rst(rst), .locked(locked),
    .pix_req(d_pix_req), .de(d_de), .hsync(d_hsync), .vsync(d_vsync),
    .hcount(d_hcount), .vcount(d_vcount), .sof(d_sof)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(0), .V_POL(0), .PREFETCH(1)
  ) u_p1 (
    .clk(clk), .rst(rst), .locked(locked),
    .pix_req(a_pix_req), .de(a_de), .hsync(a_hsync), .vsync(a_vsync),
    .hcount(a_hcount), .vcount(a_vcount), .sof(a_sof)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1), .V_POL(1), .PREFETCH(8)
  ) u_p8 (
    .clk(clk), .rst(rst), .locked(locked),
    .pix_req(b_pix_req), .de(b_de), .hsync(b_hsync), .vsync(b_vsync),
    .hcount(b_hcount), .vcount(b_vcount), .sof(b_sof)
  );

  // Expected outputs c clocks after run starts being counted (locked seen at clock 1).
  function automatic obs_t model(input int c, input int p,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input logic hp, input logic vp);
    int   ht, vt, k, h, v;
    obs_t o;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    o = '0;
    o.hsync = ~hp;
    o.vsync = ~vp;
    k = c - 3;
    if (k >= 0) begin
      h = k % ht;
      v = (k / ht) % vt;
      o.pix_req = (h < ha) && (v < va);
    end
    k = c - 3 - p;
    if (k >= 0) begin
      h = k % ht;
      v = (k / ht) % vt;
      o.de    = (h < ha) && (v < va);
      o.hsync = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
      o.vsync = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
      o.sof   = (h == 0) && (v == 0);
      o.hc    = 12'(h);
      o.vc    = 12'(v);
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input int mc, input string ph);
    check($sformatf("%s def mc=%0d", ph, mc), 32'(obs_def),
          32'(model(mc, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)));
    check($sformatf("%s p1 mc=%0d", ph, mc), 32'(obs_p1),
          32'(model(mc, 1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0)));
    check($sformatf("%s p8 mc=%0d", ph, mc), 32'(obs_p8),
          32'(model(mc, 8, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1)));
  endtask

  int de_cnt  = 0;
  int hs_cnt  = 0;
  int sof_cnt = 0;

  initial begin
    rst    = 1'b1;
    locked = 1'b1;
    repeat (3) @(negedge clk);
    check_all(0, "reset");
    check("reset hsync def", 32'(d_hsync), 32'd1);
    check("reset vsync def", 32'(d_vsync), 32'd1);
    check("reset hsync p8", 32'(b_hsync), 32'd0);
    check("reset vsync p8", 32'(b_vsync), 32'd0);
    $display("step reset: outputs checked with rst held");

    rst = 1'b0;
    for (int c = 1; c <= 1105; c++) begin
      @(negedge clk);
      check_all(c, "run");
      if (c >= 5 && c <= 804) begin
        de_cnt += int'(d_de);
        if (!d_hsync) hs_cnt++;
      end
      if (a_sof) sof_cnt++;
      if (c == 2) check("pix_req before clk3", 32'(d_pix_req), 32'd0);
      if (c == 3) check("first pix_req def", 32'(d_pix_req), 32'd1);
      if (c == 4) check("no sof def at clk4", 32'(d_sof), 32'd0);
      if (c == 5) check("first sof def", 32'(d_sof), 32'd1);
      if (c == 4) check("first sof p1", 32'(a_sof), 32'd1);
      if (c == 11) check("first sof p8", 32'(b_sof), 32'd1);
    end
    check("de per line def", 32'(de_cnt), 32'd640);
    check("hsync low per line def", 32'(hs_cnt), 32'd96);
    check("sof count p1", 32'(sof_cnt), 32'd10);
    check("hcount before unlock", 32'(d_hcount), 32'd300);
    check("vcount before unlock", 32'(d_vcount), 32'd1);
    $display("step run: 1105 clocks scanned, de=%0d hsync_low=%0d sof_p1=%0d",
             de_cnt, hs_cnt, sof_cnt);

    locked = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check_all((j <= 2) ? 1105 + j : 0, "unlock");
    end
    check("idle de after unlock", 32'(d_de), 32'd0);
    $display("step unlock: locked low for 10 clocks");

    locked = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      check_all(c, "relock");
      if (c == 5) check("sof after relock", 32'(d_sof), 32'd1);
      if (c == 5) check("hcount at relock sof", 32'(d_hcount), 32'd0);
    end
    $display("step relock: 600 clocks scanned");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
